// File: rtl/pwm_duty_rx.sv
`default_nettype none
// ============================================================================
// Module   : pwm_duty_rx
// Purpose  : Receive end of the HSMC differential PWM link. Measures the
//            period and high time of each PWM frame and recovers the 4-bit
//            duty code as floor(16*H/P) using a 5-step restoring divider.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_duty_rx #(
  parameter int CYCLE     = 30000000,
  parameter int CNT_W     = 26,
  parameter int TOL       = 64,
  parameter int TIMEOUT   = 2*CYCLE,
  parameter int FAULT_CYC = 16
) (
  input  logic       OSC_50_B8A,
  input  logic       RESET_n,
  input  logic       HSMC_RX_p,
  input  logic       HSMC_RX_n,
  output logic [3:0] duty_code,
  output logic       duty_valid,
  output logic       code_strobe,
  output logic       line_fault,
  output logic [3:0] LED
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int P_NOM = CYCLE + 1;
  localparam int P_LO  = (P_NOM > TOL) ? (P_NOM - TOL) : 0;
  localparam int P_HI  = P_NOM + TOL;
  localparam int CW1   = CNT_W + 1;
  localparam int DIV_W = CNT_W + 4;
  localparam int FLT_W = $clog2(FAULT_CYC + 1);

  localparam logic [CNT_W-1:0] C_TIMEOUT   = CNT_W'(TIMEOUT);
  localparam logic [CW1-1:0]   C_P_LO      = CW1'(P_LO);
  localparam logic [CW1-1:0]   C_P_HI      = CW1'(P_HI);
  localparam logic [FLT_W-1:0] C_FAULT_CYC = FLT_W'(FAULT_CYC);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    MEASURE = 2'd1,
    DIVIDE  = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Clock / reset aliases
  // --------------------------------------------------------------------------
  logic clk;
  logic rst_n;
  assign clk   = OSC_50_B8A;
  assign rst_n = RESET_n;

  // --------------------------------------------------------------------------
  // Signals
  // --------------------------------------------------------------------------
  logic [1:0]       sync_p_q, sync_p_d;
  logic [1:0]       sync_n_q, sync_n_d;
  logic             d_q, d_d;
  logic             d_prev_q, d_prev_d;
  logic [FLT_W-1:0] inv_cnt_q, inv_cnt_d;
  logic             line_fault_q, line_fault_d;

  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] p_lat_q, p_lat_d;
  logic [DIV_W-1:0] rem_q, rem_d;
  logic [4:0]       quot_q, quot_d;
  logic [2:0]       bit_q, bit_d;
  logic [3:0]       duty_code_q, duty_code_d;
  logic             duty_valid_q, duty_valid_d;
  logic             code_strobe_q, code_strobe_d;

  logic             rise;
  logic             period_ok;
  logic             high_ok;
  logic [DIV_W-1:0] trial;

  // --------------------------------------------------------------------------
  // Synchronizers and differential decode (hold d on p=n, count invalid run)
  // --------------------------------------------------------------------------
  always_comb begin
    sync_p_d     = {sync_p_q[0], HSMC_RX_p};
    sync_n_d     = {sync_n_q[0], HSMC_RX_n};
    d_prev_d     = d_q;
    d_d          = d_q;
    inv_cnt_d    = inv_cnt_q;
    line_fault_d = line_fault_q;
    if (sync_p_q[1] ^ sync_n_q[1]) begin
      // A valid differential sample: take its level and clear the fault state.
      d_d          = sync_p_q[1];
      inv_cnt_d    = '0;
      line_fault_d = 1'b0;
    end else begin
      if (inv_cnt_q != C_FAULT_CYC) begin
        inv_cnt_d = inv_cnt_q + FLT_W'(1);
      end
      if (inv_cnt_d == C_FAULT_CYC) begin
        line_fault_d = 1'b1;
      end
    end
  end

  // Register the synchronizer chain and the decoded line state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p_q     <= '0;
      sync_n_q     <= '0;
      d_q          <= 1'b0;
      d_prev_q     <= 1'b0;
      inv_cnt_q    <= '0;
      line_fault_q <= 1'b0;
    end else begin
      sync_p_q     <= sync_p_d;
      sync_n_q     <= sync_n_d;
      d_q          <= d_d;
      d_prev_q     <= d_prev_d;
      inv_cnt_q    <= inv_cnt_d;
      line_fault_q <= line_fault_d;
    end
  end

  assign rise = d_q & ~d_prev_q;

  // --------------------------------------------------------------------------
  // Period and high-time counters; both restart at 1 on every rising edge
  // --------------------------------------------------------------------------
  always_comb begin
    period_d = period_q;
    high_d   = high_q;
    if (rise) begin
      period_d = CNT_W'(1);
      high_d   = CNT_W'(1);
    end else begin
      if (period_q != C_TIMEOUT) begin
        period_d = period_q + CNT_W'(1);
      end
      // High count saturates rather than wrapping on a stuck-high line.
      if (d_q && (high_q != {CNT_W{1'b1}})) begin
        high_d = high_q + CNT_W'(1);
      end
    end
  end

  // Register the frame counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_q <= '0;
      high_q   <= '0;
    end else begin
      period_q <= period_d;
      high_q   <= high_d;
    end
  end

  // --------------------------------------------------------------------------
  // Frame acceptance: period within tolerance and high time shorter than period
  // --------------------------------------------------------------------------
  assign period_ok = ({1'b0, period_q} >= C_P_LO) && ({1'b0, period_q} <= C_P_HI);
  assign high_ok   = (high_q < period_q);

  // Divisor aligned to the quotient bit being resolved this cycle.
  assign trial = {4'b0000, p_lat_q} << bit_q;

  // --------------------------------------------------------------------------
  // FSM next-state, divider datapath and output registers
  // --------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    p_lat_d       = p_lat_q;
    rem_d         = rem_q;
    quot_d        = quot_q;
    bit_d         = bit_q;
    duty_code_d   = duty_code_q;
    duty_valid_d  = duty_valid_q;
    code_strobe_d = 1'b0;

    case (state_q)
      HUNT: begin
        // The first edge only starts the counters.
        if (rise) begin
          state_d = MEASURE;
        end
      end

      MEASURE: begin
        if (rise) begin
          if (period_ok && high_ok) begin
            p_lat_d = period_q;
            rem_d   = {high_q, 4'b0000};
            quot_d  = '0;
            bit_d   = 3'd4;
            state_d = DIVIDE;
          end
          // A rejected frame leaves the outputs untouched.
        end else if (period_d == C_TIMEOUT) begin
          duty_valid_d = 1'b0;
          state_d      = HUNT;
        end
      end

      DIVIDE: begin
        // One restoring step per cycle, MSB first; edges here are ignored.
        if (rem_q >= trial) begin
          rem_d  = rem_q - trial;
          quot_d = quot_q | (5'd1 << bit_q);
        end
        if (bit_q == 3'd0) begin
          duty_code_d   = quot_d[4] ? 4'hF : quot_d[3:0];
          duty_valid_d  = 1'b1;
          code_strobe_d = 1'b1;
          state_d       = MEASURE;
        end else begin
          bit_d = bit_q - 3'd1;
        end
      end

      default: begin
        state_d = HUNT;
      end
    endcase

    // A persistent invalid line overrides everything and restarts acquisition.
    if (line_fault_d) begin
      state_d       = HUNT;
      duty_valid_d  = 1'b0;
      code_strobe_d = 1'b0;
    end
  end

  // Register FSM state, divider state and the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= HUNT;
      p_lat_q       <= '0;
      rem_q         <= '0;
      quot_q        <= '0;
      bit_q         <= '0;
      duty_code_q   <= '0;
      duty_valid_q  <= 1'b0;
      code_strobe_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      p_lat_q       <= p_lat_d;
      rem_q         <= rem_d;
      quot_q        <= quot_d;
      bit_q         <= bit_d;
      duty_code_q   <= duty_code_d;
      duty_valid_q  <= duty_valid_d;
      code_strobe_q <= code_strobe_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign duty_code   = duty_code_q;
  assign duty_valid  = duty_valid_q;
  assign code_strobe = code_strobe_q;
  assign line_fault  = line_fault_q;
  assign LED         = duty_valid_q ? duty_code_q : 4'b0000;

endmodule
`default_nettype wire
